// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: four-approach green/yellow/all-red sequencer with round-robin and emergency preemption
// Ports: clk, rst_a (async, active-high); req[3:0] vehicle present (N,E,S,W);
// emg_valid/emg_dir emergency preemption; light_* one-hot {R,Y,G} per approach;
// grant one-hot served approach; phase 0 ALLRED / 1 GREEN / 2 YELLOW; pend latched requests.
module intersection_phase_scheduler #(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 2,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [3:0] req,
  input  logic       emg_valid,
  input  logic [1:0] emg_dir,
  output logic [2:0] light_n,
  output logic [2:0] light_e,
  output logic [2:0] light_s,
  output logic [2:0] light_w,
  output logic [3:0] grant,
  output logic [1:0] phase,
  output logic [3:0] pend
);
  typedef enum logic [1:0] {ALLRED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2} phase_t;
  localparam logic [CNT_W-1:0] AR_END = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] G_MIN  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] G_MAX  = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] Y_END  = CNT_W'(YELLOW_T - 1);
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cur_q, cur_d, ptr_q, ptr_d, rr_sel;
  logic [3:0]       pend_q, pend_d, pend_eff, others;
  always_comb begin
    // same-cycle requests count as pending so an idle junction can go green on the next edge
    pend_eff = pend_q | req;
    others   = pend_eff & ~(4'b1 << cur_q);
    // descending scan so the nearest approach after ptr wins
    rr_sel   = ptr_q;
    for (int k = 4; k >= 1; k--)
      if (pend_eff[ptr_q + 2'(k)]) rr_sel = ptr_q + 2'(k);
    phase_d = phase_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    pend_d  = pend_eff;
    case (phase_q)
      ALLRED:
        if (cnt_q == AR_END && (emg_valid || pend_eff != 4'b0)) begin
          phase_d = GREEN;
          cnt_d   = '0;
          cur_d   = emg_valid ? emg_dir : rr_sel;
          ptr_d   = cur_d;
          pend_d  = pend_eff & ~(4'b1 << cur_d);
        end else
          cnt_d = cnt_q == AR_END ? cnt_q : cnt_q + 1'b1;
      GREEN:
        if (emg_valid ? emg_dir != cur_q
                      : others != 4'b0 && ((cnt_q >= G_MIN && !req[cur_q]) || cnt_q == G_MAX)) begin
          phase_d = YELLOW;
          cnt_d   = '0;
        end else
          cnt_d = cnt_q == G_MAX ? cnt_q : cnt_q + 1'b1;
      YELLOW: begin
        phase_d = cnt_q == Y_END ? ALLRED : YELLOW;
        cnt_d   = cnt_q == Y_END ? '0 : cnt_q + 1'b1;
      end
      default: begin
        phase_d = ALLRED;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst_a)
    if (rst_a) begin
      phase_q <= ALLRED;
      cnt_q   <= '0;
      cur_q   <= 2'd0;
      ptr_q   <= 2'd3;
      pend_q  <= 4'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
    end
  always_comb begin
    grant   = phase_q == ALLRED ? 4'b0 : 4'b1 << cur_q;
    light_n = grant[0] ? (phase_q == GREEN ? 3'b001 : 3'b010) : 3'b100;
    light_e = grant[1] ? (phase_q == GREEN ? 3'b001 : 3'b010) : 3'b100;
    light_s = grant[2] ? (phase_q == GREEN ? 3'b001 : 3'b010) : 3'b100;
    light_w = grant[3] ? (phase_q == GREEN ? 3'b001 : 3'b010) : 3'b100;
    phase   = phase_q;
    pend    = pend_q;
  end
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler: scoreboard bench against an interval-based reference model
module tb_intersection_phase_scheduler;
  localparam int GMIN = 4, GMAX = 8, YT = 2, AR = 2;
  logic       clk = 0, rst_a = 1, emg_valid = 0;
  logic [3:0] req = 0;
  logic [1:0] emg_dir = 0;
  logic [2:0] light_n, light_e, light_s, light_w;
  logic [3:0] grant, pend;
  logic [1:0] phase;
  intersection_phase_scheduler dut (
    .clk(clk), .rst_a(rst_a), .req(req), .emg_valid(emg_valid), .emg_dir(emg_dir),
    .light_n(light_n), .light_e(light_e), .light_s(light_s), .light_w(light_w),
    .grant(grant), .phase(phase), .pend(pend)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int         cyc;
    logic [2:0] ln, le, ls, lw;
    logic [3:0] grant, pend;
    logic [1:0] phase;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  // reference model: m_ph 0 all-red, 1 green, 2 yellow; m_age is the unbounded time spent in the interval
  int       m_ph, m_age, m_cur, m_ptr;
  bit [3:0] m_pend;
  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask
  task automatic m_reset();
    m_ph = 0; m_age = 0; m_cur = 0; m_ptr = 3; m_pend = 0;
  endtask
  task automatic m_step(bit [3:0] r, bit ev, bit [1:0] ed);
    bit [3:0] pe, oth;
    bit found, go;
    pe = m_pend | r;
    if (m_ph == 0) begin
      if (m_age >= AR - 1 && (ev || pe != 0)) begin
        if (ev) m_cur = ed;
        else begin
          found = 0;
          for (int k = 1; k <= 4; k++)
            if (!found && pe[(m_ptr + k) % 4]) begin
              m_cur = (m_ptr + k) % 4;
              found = 1;
            end
        end
        m_ptr = m_cur;
        pe[m_cur] = 0;
        m_ph = 1; m_age = 0;
      end else m_age++;
    end else if (m_ph == 1) begin
      oth = pe;
      oth[m_cur] = 0;
      if (ev) go = (ed != m_cur);
      else go = oth != 0 && ((m_age >= GMIN - 1 && !r[m_cur]) || m_age >= GMAX - 1);
      if (go) begin m_ph = 2; m_age = 0; end
      else m_age++;
    end else begin
      if (m_age >= YT - 1) begin m_ph = 0; m_age = 0; end
      else m_age++;
    end
    m_pend = pe;
  endtask
  function automatic logic [2:0] m_light(int i);
    if (m_ph != 0 && m_cur == i) return m_ph == 1 ? 3'b001 : 3'b010;
    return 3'b100;
  endfunction
  task automatic push_exp(int c);
    exp_t e;
    e.cyc   = c;
    e.ln    = m_light(0);
    e.le    = m_light(1);
    e.ls    = m_light(2);
    e.lw    = m_light(3);
    e.grant = m_ph != 0 ? 4'(1 << m_cur) : 4'b0;
    e.phase = 2'(m_ph);
    e.pend  = m_pend;
    sb.push_back(e);
  endtask
  task automatic step(logic [3:0] r, logic ev, logic [1:0] ed);
    @(posedge clk);
    #1;
    rst_a = 0; req = r; emg_valid = ev; emg_dir = ed;
    m_step(r, ev, ed);
    push_exp(cyc + 1);
  endtask
  task automatic idle(int n, logic [3:0] r);
    for (int i = 0; i < n; i++) step(r, 1'b0, 2'd0);
  endtask
  task automatic do_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_a = 1; req = 0; emg_valid = 0;
    m_reset();
    push_exp(cyc);
  endtask
  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      int nr;
      e = sb.pop_front();
      chk("light_n", light_n, e.ln);
      chk("light_e", light_e, e.le);
      chk("light_s", light_s, e.ls);
      chk("light_w", light_w, e.lw);
      chk("grant", grant, e.grant);
      chk("phase", phase, e.phase);
      chk("pend", pend, e.pend);
      nr = int'(light_n != 3'b100) + int'(light_e != 3'b100) + int'(light_s != 3'b100) + int'(light_w != 3'b100);
      chk("one_nonred", 8'(nr <= 1), 8'd1);
    end
  end
  initial begin
    int emg_left;
    logic [3:0] r, hold;
    logic [1:0] ed;
    do_reset();
    idle(20, 4'b0000);
    do_reset();
    idle(5, 4'b0000);
    step(4'b0001, 0, 0);
    idle(35, 4'b0000);
    do_reset();
    idle(3, 4'b0000);
    step(4'b0001, 0, 0);
    step(4'b0011, 0, 0);
    idle(20, 4'b0001);
    idle(6, 4'b0000);
    do_reset();
    idle(3, 4'b0000);
    step(4'b0001, 0, 0);
    step(4'b0011, 0, 0);
    step(4'b0001, 0, 0);
    idle(20, 4'b0000);
    do_reset();
    idle(3, 4'b0000);
    step(4'b0010, 0, 0);
    step(4'b1111, 0, 0);
    idle(60, 4'b0000);
    do_reset();
    idle(3, 4'b0000);
    step(4'b0001, 0, 0);
    idle(2, 4'b0000);
    for (int i = 0; i < 20; i++) step(4'b0001, 1'b1, 2'd2);
    idle(30, 4'b0000);
    step(4'b0100, 0, 0);
    idle(3, 4'b0000);
    do_reset();
    idle(3, 4'b0000);
    emg_left = 0; ed = 0; hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        emg_left = 0;
      end
      if ($urandom_range(0, 15) == 0) hold = 4'($urandom) & 4'($urandom);
      r = hold | (($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0);
      if ($urandom_range(0, 7) == 0) ed = 2'($urandom);
      if (emg_left == 0 && $urandom_range(0, 60) == 0) emg_left = $urandom_range(3, 15);
      step(r, emg_left > 0, ed);
      if (emg_left > 0) emg_left--;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drain", 8'(sb.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Four-approach intersection phase scheduler that grants right-of-way (green) to one approach at a time. It sequences each phase through green, yellow and all-red intervals and latches vehicle requests. It arbitrates round-robin among pending approaches and gives preemption to an emergency request. It drives the per-approach light outputs of the traffic controller subsystem.

## Interface
- GREEN_MIN, 4: minimum green duration, clk cycles (≥1)
- GREEN_MAX, 8: maximum green duration when another approach is pending (≥ GREEN_MIN)
- YELLOW_T, 2: yellow duration, clk cycles (≥1)
- ALLRED_T, 2: minimum all-red clearance, clk cycles (≥1)
- CNT_W, 4: phase counter width; must hold GREEN_MAX-1
- clk  in  1  clock; all state updates on rising edge
- rst_a  in  1  asynchronous, active-high reset
- req  in  4  vehicle-present level per approach; bit0 N, bit1 E, bit2 S, bit3 W
- emg_valid  in  1  emergency preemption active (level)
- emg_dir  in  2  approach index requested by emergency
- light_n, light_e, light_s, light_w  out  3 each  one-hot {R,Y,G}: 3'b100 red, 3'b010 yellow, 3'b001 green
- grant  out  4  one-hot current green/yellow approach; 0 during all-red
- phase  out  2  0 ALLRED, 1 GREEN, 2 YELLOW (3 unused)
- pend  out  4  latched pending requests

## Operation
- Registers: phase state, cnt (CNT_W), cur (2-bit current approach), ptr (2-bit last-granted), pend (4).
- Reset: phase ALLRED, cnt 0, cur 0, ptr 3 (first search starts at N), pend 0; grant 0, all lights 3'b100.
- pend[i] set every cycle req[i]=1; cleared on the cycle approach i enters GREEN (clear wins over simultaneous set).
- ALLRED: cnt increments, saturating at ALLRED_T-1. Exit when cnt==ALLRED_T-1 and (emg_valid or pend≠0): emg_valid → cur=emg_dir; else cur = first set bit of pend searching ptr+1, ptr+2, ... mod 4. On exit: phase GREEN, cnt 0, ptr=cur. If neither condition holds, stay in all-red.
- GREEN: cnt increments, saturating at GREEN_MAX-1. Let others = pend & ~(1<<cur).
  - emg_valid and emg_dir≠cur → YELLOW next cycle regardless of cnt.
  - emg_valid and emg_dir==cur → hold GREEN; GREEN_MAX is ignored.
  - otherwise others≠0 and cnt≥GREEN_MIN-1 and req[cur]==0 → YELLOW (gap-out).
  - otherwise others≠0 and cnt==GREEN_MAX-1 → YELLOW (max-out).
  - others==0 → hold GREEN indefinitely (rest in green).
- YELLOW: YELLOW_T cycles (cnt 0..YELLOW_T-1), then ALLRED with cnt 0. Emergency does not shorten yellow.
- Lights: approach cur is green in GREEN and yellow in YELLOW. All other approaches, and all approaches in ALLRED, are red. grant = 1<<cur in GREEN/YELLOW, else 0.
- emg_dir is sampled only at the ALLRED exit and during GREEN. Deassertion of emg_valid resumes the normal rules using the current cnt.

## Timing
- Outputs are decoded only from registered state. A light change is visible in the same cycle the phase register updates, with no extra pipeline.
- Request-to-green latency: a request pulse in cycle t, with the block idle in ALLRED and cnt saturated, gives green at t+1.
- Green length with contention is GREEN_MIN..GREEN_MAX cycles. Yellow is exactly YELLOW_T cycles. All-red is at least ALLRED_T cycles.
- Asserting rst_a mid-phase forces the reset values immediately: all lights red, pend cleared.
- At most one approach is non-red in any cycle. No green follows yellow without ≥ALLRED_T cycles of all-red.

## Test plan
- Reset, then no req for 20 cycles → all lights 3'b100, grant 0, phase 0 throughout.
- req[0] one-cycle pulse at cycle 5 after reset → light_n 3'b001 from cycle 6, grant 4'b0001. It stays green at cycle 40 with no other requests.
- N green with req[0] held high, pulse req[1] at green cycle 0 → green lasts 8 cycles (max-out), yellow 2, all-red 2, then light_e green, ptr=1.
- Same as above but req[0] drops at green cycle 1 → yellow after green cycle 3 (4-cycle green, gap-out).
- pend=4'b1111 with ptr=1 at all-red exit → grant order S, W, N, E.
- N green at cycle 2, emg_valid=1, emg_dir=2 → yellow next cycle, 2 yellow + 2 all-red, then S green. S green holds past 8 cycles while emg_valid=1 and pend[0]=1. It yields by gap-out/max-out after emg_valid drops.
